instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage of the RV32I multi-cycle CPU. It owns the program counter and drives the instruction ROM address. It latches the returned word into the instruction register (IR) under a small handshake FSM. It also computes the next PC (sequential, branch/JAL, or JALR) when the control unit commands a PC update.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ROM_LATENCY, 0, extra wait cycles before sampling instr_data (legal range 0..3); 0 suits the current combinational ROM, 1+ suits a future registered/BRAM ROM

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
fetch_req  input  1  control unit request to fetch the instruction at the current pc
pc_load  input  1  control unit command to update pc this cycle
pc_src  input  2  next-PC select: 0 = pc+4, 1 = pc+imm (branch taken / JAL), 2 = (rs1_data+imm) & ~1 (JALR), 3 = reserved (treated as 0)
imm  input  32  sign-extended immediate from the immediate generator
rs1_data  input  32  register-file rs1 read value (JALR base)
instr_data  input  32  instruction word returned by the ROM
instr_addr  output  32  byte address to the ROM; always equals pc (ROM indexes addr[31:2])
pc  output  32  current program counter
pc_plus4  output  32  pc+4, combinational (JAL/JALR link value)
ir  output  32  latched instruction register
ir_pc  output  32  pc value at which ir was fetched
instr_valid  output  1  one-cycle pulse: ir/ir_pc updated this cycle
busy  output  1  fetch in progress
misalign_fault  output  1  sticky: a PC update targeted a non-word-aligned address

Behaviour:
- Reset (async, any state): pc=RESET_PC, ir=32'h0000_0013 (addi x0,x0,0), ir_pc=RESET_PC, instr_valid=0, busy=0, misalign_fault=0, FSM=IDLE, wait counter=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: fetch_req=1 and pc_load=0 → load counter with ROM_LATENCY and go to WAIT; busy rises the next cycle.
  - WAIT: busy=1. If counter≠0, decrement. If counter=0, capture ir<=instr_data and ir_pc<=pc, then go to DONE.
  - DONE: instr_valid=1 for exactly this one cycle, busy=0; then return to IDLE.
- Latency: fetch_req accepted at edge N → instr_valid high in cycle N+2+ROM_LATENCY.
- pc holds constant from acceptance until DONE, so instr_addr stays stable throughout the ROM access.
- fetch_req while busy or in DONE: ignored, no queuing.
- pc_load is honoured only in IDLE; in WAIT/DONE it is ignored and pc is unchanged.
- pc_load and fetch_req together in IDLE: pc_load wins, pc updates, fetch_req is dropped. The control unit must re-assert fetch_req next cycle.
- Next-PC arithmetic is 32-bit modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0. pc_src=2 clears bit 0 before the alignment check.
- Alignment: a computed target with bits[1:0]≠0 is not loaded; pc holds its value. misalign_fault sets and stays set until reset. Later aligned pc_loads still proceed.
- instr_data is sampled only in the WAIT cycle with counter=0; its value at all other times is irrelevant.
- Reset mid-fetch: the fetch is aborted, no instr_valid pulse, and ir returns to the NOP value.

Test Plan:
- Reset then fetch: RESET_PC=0, ROM word0=32'h0041_8033, fetch_req pulse → instr_valid 2 cycles later (ROM_LATENCY=0), ir=32'h0041_8033, ir_pc=0, instr_addr=0 throughout.
- Sequential: pc_load with pc_src=0 three times, interleaved with fetches → pc 4, 8, 12; each ir matches ROM[1..3]; pc_plus4 always equals pc+4.
- Branch/JALR: pc=8, imm=16, pc_src=1 → pc=24; rs1_data=32'h0000_0025, imm=30, pc_src=2 → target 0x43 & ~1 = 0x42 is misaligned → pc stays 24, misalign_fault=1 and stays 1 after a later aligned load.
- Busy rules with ROM_LATENCY=2: during a fetch, assert fetch_req and pc_load(pc_src=1) → both ignored, pc unchanged, single instr_valid 4 cycles after acceptance.
- Priority/wrap: pc=32'hFFFF_FFFC, fetch_req and pc_load(pc_src=0) in the same IDLE cycle → pc=0, no fetch, instr_valid stays 0.
- Reset mid-WAIT (ROM_LATENCY=3): assert reset → busy=0 immediately, ir=32'h0000_0013, pc=RESET_PC, no instr_valid pulse afterwards.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV32I multi-cycle CPU: owns the PC, drives the ROM address,
// latches the returned word into IR through an IDLE/WAIT/DONE handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_LATENCY = 0  // extra ROM wait cycles, legal range 0..3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_req_i,
  input  logic        pc_load_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] instr_data_i,
  output logic [31:0] instr_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] ir_o,
  output logic [31:0] ir_pc_o,
  output logic        instr_valid_o,
  output logic        busy_o,
  output logic        misalign_fault_o
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;
  localparam logic [1:0]  LatInit  = 2'(ROM_LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    case (pc_src_i)
      2'd1:    target = pc_q + imm_i;
      2'd2:    target = (rs1_data_i + imm_i) & ~32'd1;
      default: target = pc_plus4;  // 3 is reserved and behaves as sequential
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        // A PC update takes priority; a coincident fetch request is dropped.
        if (pc_load_i) begin
          if (target[1:0] != 2'b00) begin
            fault_d = 1'b1;
          end else begin
            pc_d = target;
          end
        end else if (fetch_req_i) begin
          cnt_d   = LatInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          ir_d    = instr_data_i;
          ir_pc_d = pc_q;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      pc_q    <= RESET_PC;
      ir_q    <= NopInstr;
      ir_pc_q <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      fault_q <= fault_d;
    end
  end

  assign instr_addr_o     = pc_q;
  assign pc_o             = pc_q;
  assign pc_plus4_o       = pc_plus4;
  assign ir_o             = ir_q;
  assign ir_pc_o          = ir_pc_q;
  assign instr_valid_o    = (state_q == StDone);
  assign busy_o           = (state_q == StWait);
  assign misalign_fault_o = fault_q;

endmodule
